cdc_handshake_tx: RTL and testbench
===================================

// Module: cdc_handshake_tx
// PURPOSE
//  Source-domain (transmit) end of a 4-phase req/ack clock-domain-crossing handshake.
//  Captures a data word, holds it stable on o_data and raises o_req toward the destination.
//  Waits for the destination's acknowledge, brought in through an internal SYNC_STAGES flop
//  synchronizer, then completes the return-to-zero phase.
//  Pairs with a destination-side receiver that double-flops o_req.
//  Single clock; i_ack is asynchronous to it.
// PARAMETERS
//  DATA_WIDTH   8  width of the transferred word
//  SYNC_STAGES  2  flops in the i_ack synchronizer chain (>=2)
// PORTS
//  i_clk    in   1           source-domain clock, rising edge
//  i_rst    in   1           synchronous reset, active-high
//  i_valid  in   1           source offers i_data this cycle
//  i_data   in   DATA_WIDTH  word to transfer
//  o_ready  out  1           block can accept a word this cycle
//  o_req    out  1           request to destination (registered, glitch-free)
//  o_data   out  DATA_WIDTH  held word; stable whenever o_req=1
//  i_ack    in   1           acknowledge from destination domain (asynchronous)
//  o_done   out  1           1-cycle pulse: transfer fully completed
// BEHAVIOUR
//  - Reset (i_rst=1 at a rising edge): state=IDLE, o_req=0, o_data=0, o_done=0, all sync flops=0.
//  - ack_s = last stage of the i_ack chain; only ack_s is used by the FSM.
//  - o_ready = (state==IDLE) && !ack_s. This is combinational from registers and does not depend on i_valid.
//  - Accept: at an edge where i_valid && o_ready, load o_data<=i_data, o_req<=1, state->REQ.
//    o_req is visible 1 cycle after accept.
//  - REQ: o_req=1, o_data frozen. When ack_s=1: o_req<=0, state->DROP.
//  - DROP: o_req=0. When ack_s=0: state->IDLE, o_done<=1 for exactly one cycle.
//  - o_data changes only on accept. It keeps its value after completion until the next accept.
//  - i_valid while not ready is ignored; no word is queued. The source must hold i_valid.
//  - i_ack high while IDLE (spurious or stale): remain IDLE, o_ready=0 until ack_s returns to 0. No o_done.
//  - i_ack dropping during REQ before ack_s was seen: no effect; stay in REQ.
//  - Latency with SYNC_STAGES=2 and i_ack changing before an edge:
//    o_req falls on the 3rd edge after i_ack rises; IDLE/o_done on the 3rd edge after i_ack falls.
//  - Reset mid-transfer: abort immediately to the reset values. The destination must see o_req=0
//    and drop ack; o_ready stays 0 until ack_s=0.
//  - No combinational path from i_ack to any output.
// TESTING
//  1 Reset: hold i_rst 2 cycles, i_ack=0 -> o_req=0, o_data=0, o_done=0, o_ready=1.
//  2 Single transfer: i_valid=1, i_data=8'hA5 one cycle -> next cycle o_req=1, o_data=A5, o_ready=0;
//    raise i_ack -> o_req=0 on 3rd edge; drop i_ack -> o_done=1 one cycle on 3rd edge, o_ready=1.
//  3 Hold stability: during REQ, toggle i_data/i_valid randomly -> o_data stays A5,
//    no second accept until o_done.
//  4 Spurious ack: i_ack=1 while IDLE -> o_ready=0 after 2 edges, no state change, no o_done;
//    release -> o_ready=1.
//  5 Reset mid-REQ: assert i_rst with o_req=1, i_ack=1 -> o_req=0, o_data=0 next edge;
//    o_ready=0 until i_ack dropped plus 2 edges.
//  6 Back-to-back: 20 random words with a modelled 2-flop receiver and random ack delay ->
//    each word seen exactly once, in order, one o_done per word.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cdc_handshake_tx
//  Description : Source-domain end of a 4-phase req/ack clock-domain-crossing
//                handshake. Captures one word, holds it on o_data while o_req
//                is high, waits for the synchronised acknowledge, then
//                completes the return-to-zero phase and pulses o_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_req,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ack,
    output logic                  o_done
);

    // Handshake phases: waiting for a word, request raised, waiting for ack release
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;

    logic [1:0]             r_state;
    logic                   r_req;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_done;

    logic [1:0]             w_state_nxt;
    logic                   w_req_nxt;
    logic [DATA_WIDTH-1:0]  w_data_nxt;
    logic                   w_done_nxt;
    logic                   w_ready;
    logic                   w_accept;

    // Multi-flop synchroniser for the asynchronous acknowledge; only the last stage is used
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // A stale or spurious ack blocks new words until the destination has released it
    assign w_ready  = (r_state == S_IDLE) && !w_ack_s;
    assign w_accept = i_valid && w_ready;

    // Next-state and next-output logic of the 4-phase handshake
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_data_nxt  = i_data;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // An ack pulse that never reached the synchroniser output is ignored
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (!w_ack_s) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; o_req comes straight from a flop so it cannot glitch
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_ready = w_ready;
    assign o_req   = r_req;
    assign o_data  = r_data;
    assign o_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_handshake_tx
//  Description : Self-checking bench for cdc_handshake_tx with a cycle model
//                of the handshake and directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [DW-1:0] data;
    logic          ack;
    logic          ready;
    logic          req;
    logic [DW-1:0] odata;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    cdc_handshake_tx #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_data  (data),
        .o_ready (ready),
        .o_req   (req),
        .o_data  (odata),
        .i_ack   (ack),
        .o_done  (done)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a word is outstanding from accept until done; the request is up
    // until the delayed ack is seen; the ack seen by the block is i_ack
    // delayed by SS edges, cleared by reset.
    bit          m_ok = 1'b0;
    bit          m_busy, m_req, m_done;
    bit [DW-1:0] m_data;
    bit          m_ack [SS];

    always @(posedge clk) begin : model
        bit acks;
        acks = m_ack[SS-1];
        if (rst) begin
            m_ok   = 1'b1;
            m_busy = 1'b0;
            m_req  = 1'b0;
            m_done = 1'b0;
            m_data = '0;
            for (int i = 0; i < SS; i++) m_ack[i] = 1'b0;
        end else if (m_ok) begin
            m_done = 1'b0;
            if (!m_busy && !acks && valid) begin
                m_busy = 1'b1;
                m_req  = 1'b1;
                m_data = data;
            end else if (m_busy && m_req && acks) begin
                m_req = 1'b0;
            end else if (m_busy && !m_req && !acks) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
            for (int i = SS - 1; i > 0; i--) m_ack[i] = m_ack[i-1];
            m_ack[0] = ack;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_ok) begin
            check("cyc_req",   req,   m_req);
            check("cyc_data",  odata, m_data);
            check("cyc_done",  done,  m_done);
            check("cyc_ready", ready, !m_busy && !m_ack[SS-1]);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic logic sel(input int which);
        case (which)
            0: sel = ready;
            1: sel = req;
            default: sel = done;
        endcase
    endfunction

    task automatic wait_sig(input string nm, input int which, input logic lvl);
        int n;
        n = 0;
        while (sel(which) !== lvl && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [DW-1:0] txq [$];
    logic [DW-1:0] rxq [$];
    logic [DW-1:0] wd;
    int            d0;

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        ack   = 1'b0;

        // 1: reset
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_req",   req,   0);
        check("rst_data",  odata, 0);
        check("rst_done",  done,  0);
        check("rst_ready", ready, 1);

        // 2: single transfer
        tick();
        valid = 1'b1; data = 8'hA5;
        tick();
        valid = 1'b0; data = 8'h00;
        settle();
        check("t2_req",   req,   1);
        check("t2_data",  odata, 8'hA5);
        check("t2_ready", ready, 0);
        tick();
        ack = 1'b1;
        tick(); tick();
        settle();
        check("t2_req_2edges", req, 1);
        tick();
        settle();
        check("t2_req_3edges", req, 0);
        ack = 1'b0;
        tick(); tick();
        settle();
        check("t2_done_2edges", done, 0);
        tick();
        settle();
        check("t2_done_3edges",  done,  1);
        check("t2_ready_3edges", ready, 1);
        tick();
        settle();
        check("t2_done_pulse", done, 0);
        check("t2_data_kept",  odata, 8'hA5);

        // 3: hold stability under input noise
        tick();
        valid = 1'b1; data = 8'hC3;
        tick();
        for (int i = 0; i < 8; i++) begin
            valid = 1'($urandom);
            data  = 8'($urandom);
            settle();
            check("t3_hold", odata, 8'hC3);
            tick();
        end
        valid = 1'b0;
        ack = 1'b1;
        tick(); tick(); tick();
        ack = 1'b0;
        tick(); tick();
        settle();
        check("t3_no_done_yet", done, 0);
        tick();
        settle();
        check("t3_done", done, 1);

        // 4: spurious ack while idle
        tick();
        ack = 1'b1;
        tick();
        settle();
        check("t4_ready_1edge", ready, 1);
        tick();
        settle();
        check("t4_ready_2edges", ready, 0);
        valid = 1'b1; data = 8'h99;
        tick(); tick(); tick();
        settle();
        check("t4_no_req",  req,  0);
        check("t4_no_done", done, 0);
        valid = 1'b0;
        ack = 1'b0;
        tick();
        settle();
        check("t4_ready_rel1", ready, 0);
        tick();
        settle();
        check("t4_ready_rel2", ready, 1);

        // 5: reset mid-request with ack high
        tick();
        valid = 1'b1; data = 8'h77;
        tick();
        valid = 1'b0;
        settle();
        check("t5_req", req, 1);
        ack = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("t5_rst_req",  req,   0);
        check("t5_rst_data", odata, 0);
        tick(); tick();
        settle();
        check("t5_ready_ackhi", ready, 0);
        ack = 1'b0;
        tick();
        settle();
        check("t5_ready_rel1", ready, 0);
        tick();
        settle();
        check("t5_ready_rel2", ready, 1);
        check("t5_no_done",    done,  0);

        // 6: back-to-back words through a modelled 2-flop receiver
        d0 = done_cnt;
        for (int w = 0; w < 20; w++) begin
            wd = 8'($urandom);
            wait_sig("t6_ready", 0, 1'b1);
            valid = 1'b1; data = wd;
            txq.push_back(wd);
            tick();
            valid = 1'b0; data = 8'($urandom);
            wait_sig("t6_req", 1, 1'b1);
            tick(); tick();
            rxq.push_back(odata);
            repeat ($urandom_range(0, 3)) tick();
            ack = 1'b1;
            wait_sig("t6_req_low", 1, 1'b0);
            tick(); tick();
            repeat ($urandom_range(0, 3)) tick();
            ack = 1'b0;
            wait_sig("t6_done", 2, 1'b1);
        end
        tick(); tick();
        check("t6_done_count", done_cnt - d0, 20);
        check("t6_rx_count",   rxq.size(),    txq.size());
        for (int i = 0; i < txq.size() && i < rxq.size(); i++) begin
            check("t6_word", rxq[i], txq[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
